// File: rtl/types_pkg.sv
// Shared parity configuration types for the parity FIFO and its check stage.
package types_pkg;

   typedef enum logic {
      EVEN = 1'b0,
      ODD  = 1'b1
   } parity_mode_t;

   typedef enum logic {
      LSB = 1'b0,
      MSB = 1'b1
   } parity_bit_choice_t;

   localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/skid_buffer_2.sv
// Generic 2-entry valid/grant buffer, FIFO order.
// Input grant depends only on the registered fill count.
module skid_buffer_2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             in_grant_o,
   output logic             out_valid_o,
   output logic [WIDTH-1:0] out_data_o,
   input  logic             out_grant_i
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_head;
   logic [1:0]       r_count;

   logic w_push;
   logic w_pop;
   logic w_tail;

   assign in_grant_o  = ~r_count[1];
   assign out_valid_o = |r_count;
   assign out_data_o  = out_valid_o ? r_mem[r_head] : '0;

   assign w_push = in_valid_i & in_grant_o;
   assign w_pop  = out_grant_i & out_valid_o;
   assign w_tail = r_head ^ r_count[0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_head   <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push)
            r_mem[w_tail] <= in_data_i;
         if (w_pop)
            r_head <= ~r_head;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

endmodule

// File: rtl/parity_check_stage.sv
// Parity check/strip stage behind the parity FIFO, with a 2-entry
// output buffer and a saturating parity error counter.
module parity_check_stage
   import types_pkg::*;
#(
   parameter int                 DATA_WIDTH        = 8,
   parameter parity_mode_t       PARITY_MODE       = ODD,
   parameter parity_bit_choice_t PARITY_BIT_CHOICE = MSB,
   parameter int                 DROP_ON_ERROR     = 0,
   parameter int                 ERR_CNT_WIDTH     = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     valid_i,
   input  logic [DATA_WIDTH-1:0]    data_i,
   output logic                     grant_o,
   output logic                     valid_o,
   output logic [DATA_WIDTH-2:0]    data_o,
   output logic                     perr_o,
   input  logic                     grant_i,
   input  logic                     err_clear_i,
   output logic [ERR_CNT_WIDTH-1:0] err_count_o
);

   localparam int PW = DATA_WIDTH - 1;

   logic          w_bad;
   logic [PW-1:0] w_payload;
   logic          w_buf_valid;
   logic          w_accept;
   logic          w_err;
   logic [PW:0]   w_head;

   logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

   assign w_bad     = (^data_i) ^ (PARITY_MODE == ODD);
   assign w_payload = (PARITY_BIT_CHOICE == MSB) ? data_i[DATA_WIDTH-2:0]
                                                 : data_i[DATA_WIDTH-1:1];

   // Dropped words are granted but never written to the buffer.
   assign w_buf_valid = valid_i & ~((DROP_ON_ERROR != 0) & w_bad);
   assign w_accept    = valid_i & grant_o;
   assign w_err       = w_accept & w_bad;

   skid_buffer_2 #(
      .WIDTH (PW + 1)
   ) u_buf (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid_i  (w_buf_valid),
      .in_data_i   ({w_payload, w_bad}),
      .in_grant_o  (grant_o),
      .out_valid_o (valid_o),
      .out_data_o  (w_head),
      .out_grant_i (grant_i)
   );

   assign data_o = w_head[PW:1];
   assign perr_o = (DROP_ON_ERROR != 0) ? 1'b0 : w_head[0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err_cnt <= '0;
      end else if (err_clear_i) begin
         r_err_cnt <= w_err ? ERR_CNT_WIDTH'(1) : '0;
      end else if (w_err && (r_err_cnt != '1)) begin
         r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign err_count_o = r_err_cnt;

endmodule

// File: tb/tb_parity_check_stage.sv
// Directed bench: four stage instances covering default, drop,
// narrow-counter and EVEN/LSB configurations.
module tb_parity_check_stage;
   import types_pkg::*;

   logic       clk;
   logic       reset_n;
   logic       v   [4];
   logic [7:0] d   [4];
   logic       g   [4];
   logic       clr [4];
   logic       go  [4];
   logic       vo  [4];
   logic [6:0] dout[4];
   logic       pe  [4];
   logic [7:0] cnt0, cnt1, cnt3;
   logic [1:0] cnt2;

   int n_chk  = 0;
   int n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   parity_check_stage u0 (
      .clk(clk), .reset_n(reset_n), .valid_i(v[0]), .data_i(d[0]),
      .grant_o(go[0]), .valid_o(vo[0]), .data_o(dout[0]), .perr_o(pe[0]),
      .grant_i(g[0]), .err_clear_i(clr[0]), .err_count_o(cnt0));

   parity_check_stage #(.DROP_ON_ERROR(1)) u1 (
      .clk(clk), .reset_n(reset_n), .valid_i(v[1]), .data_i(d[1]),
      .grant_o(go[1]), .valid_o(vo[1]), .data_o(dout[1]), .perr_o(pe[1]),
      .grant_i(g[1]), .err_clear_i(clr[1]), .err_count_o(cnt1));

   parity_check_stage #(.ERR_CNT_WIDTH(2)) u2 (
      .clk(clk), .reset_n(reset_n), .valid_i(v[2]), .data_i(d[2]),
      .grant_o(go[2]), .valid_o(vo[2]), .data_o(dout[2]), .perr_o(pe[2]),
      .grant_i(g[2]), .err_clear_i(clr[2]), .err_count_o(cnt2));

   parity_check_stage #(.PARITY_MODE(EVEN), .PARITY_BIT_CHOICE(LSB)) u3 (
      .clk(clk), .reset_n(reset_n), .valid_i(v[3]), .data_i(d[3]),
      .grant_o(go[3]), .valid_o(vo[3]), .data_o(dout[3]), .perr_o(pe[3]),
      .grant_i(g[3]), .err_clear_i(clr[3]), .err_count_o(cnt3));

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         v[i] = 1'b0; d[i] = 8'h00; g[i] = 1'b0; clr[i] = 1'b0;
      end
      step();
      step();
      chk("rst_valid", 8'(vo[0]), 8'h00);
      chk("rst_data",  8'(dout[0]), 8'h00);
      chk("rst_perr",  8'(pe[0]), 8'h00);
      chk("rst_grant", 8'(go[0]), 8'h01);
      chk("rst_cnt",   cnt0, 8'h00);
      reset_n = 1'b1;
      step();

      // good word, immediate visibility
      g[0] = 1'b1; v[0] = 1'b1; d[0] = 8'b1000_0000;
      step();
      v[0] = 1'b0;
      chk("good_valid", 8'(vo[0]), 8'h01);
      chk("good_data",  8'(dout[0]), 8'h00);
      chk("good_perr",  8'(pe[0]), 8'h00);
      chk("good_cnt",   cnt0, 8'h00);
      step();
      chk("good_drain", 8'(vo[0]), 8'h00);

      // bad word forwarded with tag
      v[0] = 1'b1; d[0] = 8'b0000_0011;
      step();
      v[0] = 1'b0;
      chk("bad_valid", 8'(vo[0]), 8'h01);
      chk("bad_data",  8'(dout[0]), 8'h03);
      chk("bad_perr",  8'(pe[0]), 8'h01);
      chk("bad_cnt",   cnt0, 8'h01);
      step();

      // bad word dropped
      g[1] = 1'b1; v[1] = 1'b1; d[1] = 8'b0000_0011;
      step();
      v[1] = 1'b0;
      chk("drop_valid", 8'(vo[1]), 8'h00);
      chk("drop_cnt",   cnt1, 8'h01);
      chk("drop_grant", 8'(go[1]), 8'h01);

      // backpressure: three words with consumer stalled
      g[0] = 1'b0; v[0] = 1'b1; d[0] = 8'h01;
      step();
      chk("bp1_grant", 8'(go[0]), 8'h01);
      chk("bp1_data",  8'(dout[0]), 8'h01);
      d[0] = 8'h02;
      step();
      chk("bp2_grant", 8'(go[0]), 8'h00);
      d[0] = 8'h04;
      step();
      chk("bp3_grant", 8'(go[0]), 8'h00);
      chk("bp3_head",  8'(dout[0]), 8'h01);
      g[0] = 1'b1;
      step();
      chk("bp_out2",   8'(dout[0]), 8'h02);
      chk("bp_regrnt", 8'(go[0]), 8'h01);
      step();
      v[0] = 1'b0;
      chk("bp_out3",   8'(dout[0]), 8'h04);
      chk("bp_v3",     8'(vo[0]), 8'h01);
      step();
      chk("bp_empty",  8'(vo[0]), 8'h00);
      chk("bp_cnt",    cnt0, 8'h01);

      // 2-bit counter saturation then clear with coincident error
      g[2] = 1'b1; v[2] = 1'b1; d[2] = 8'b0000_0011;
      step(); chk("sat1", 8'(cnt2), 8'h01);
      step(); chk("sat2", 8'(cnt2), 8'h02);
      step(); chk("sat3", 8'(cnt2), 8'h03);
      step(); chk("sat4", 8'(cnt2), 8'h03);
      step(); chk("sat5", 8'(cnt2), 8'h03);
      clr[2] = 1'b1;
      step(); chk("clr_err", 8'(cnt2), 8'h01);
      v[2] = 1'b0;
      step(); chk("clr_only", 8'(cnt2), 8'h00);
      clr[2] = 1'b0;

      // EVEN parity, LSB parity bit
      g[3] = 1'b1; v[3] = 1'b1; d[3] = 8'b0000_0011;
      step();
      v[3] = 1'b0;
      chk("even_valid", 8'(vo[3]), 8'h01);
      chk("even_data",  8'(dout[3]), 8'h01);
      chk("even_perr",  8'(pe[3]), 8'h00);
      chk("even_cnt",   cnt3, 8'h00);

      // async reset with two words buffered
      g[0] = 1'b0; v[0] = 1'b1; d[0] = 8'h01;
      step();
      d[0] = 8'h02;
      step();
      v[0] = 1'b0;
      chk("pre_rst_grant", 8'(go[0]), 8'h00);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_valid", 8'(vo[0]), 8'h00);
      chk("arst_cnt",   cnt0, 8'h00);
      chk("arst_grant", 8'(go[0]), 8'h01);
      step();
      reset_n = 1'b1;
      g[0] = 1'b1; v[0] = 1'b1; d[0] = 8'b1000_0000;
      step();
      v[0] = 1'b0;
      chk("post_valid", 8'(vo[0]), 8'h01);
      chk("post_data",  8'(dout[0]), 8'h00);
      chk("post_perr",  8'(pe[0]), 8'h00);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/parity_check_stage.md
# parity_check_stage

Downstream stage of the parity FIFO (`top`): pops words from the FIFO's valid/grant output, checks the parity bit embedded in each word, strips it, and re-presents the payload on its own valid/grant interface. A 2-entry output buffer decouples FIFO pops from the consumer's grant, and a saturating error counter records parity failures. Errored words are either forwarded with an error tag or discarded, per parameter.

## Interface
- `DATA_WIDTH`, 8: width of the incoming word including the parity bit; payload is `DATA_WIDTH-1` bits.
- `PARITY_MODE`, ODD: `parity_mode_t`; ODD means the full word (payload + parity bit) holds an odd number of ones.
- `PARITY_BIT_CHOICE`, MSB: `parity_bit_choice_t`; position of the parity bit in the incoming word.
- `DROP_ON_ERROR`, 0: 1 = errored words are consumed and discarded; 0 = forwarded with `perr_o`=1.
- `ERR_CNT_WIDTH`, 8: width of the error counter.

Ports:
- `clk`  in  1  clock, all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  upstream word valid (FIFO `valid_o`).
- `data_i`  in  DATA_WIDTH  upstream word with parity (FIFO `data_o`).
- `grant_o`  out  1  stage accepts; drives the FIFO `grant_i`.
- `valid_o`  out  1  payload valid to consumer.
- `data_o`  out  DATA_WIDTH-1  stripped payload.
- `perr_o`  out  1  parity-error tag of the word on `data_o` (always 0 when `DROP_ON_ERROR`=1).
- `grant_i`  in  1  consumer accepts `data_o` this cycle.
- `err_clear_i`  in  1  synchronous clear of the error counter.
- `err_count_o`  out  ERR_CNT_WIDTH  number of parity errors seen, saturating.

## Operation
- Transfer rule, both sides: a word moves on a rising edge where valid and grant are both 1. Upstream valid/data are held by the FIFO until granted.
- Check: `bad = ^data_i ^ (PARITY_MODE==ODD)`; ODD: bad when XOR of all bits is 0; EVEN: bad when it is 1.
- Strip: MSB choice -> payload `data_i[DATA_WIDTH-2:0]`; LSB choice -> `data_i[DATA_WIDTH-1:1]`.
- Buffer: 2 entries of {payload, bad}, FIFO order; `valid_o` = count != 0; `data_o`/`perr_o` = head entry.
- `grant_o` = count < 2, derived from registered count only (no combinational path from `grant_i` or `valid_i`).
- Accepted bad word with `DROP_ON_ERROR`=1: consumed, not written, count unchanged by it.
- Counter: +1 on each accepted bad word; holds at all-ones. `err_clear_i` with no simultaneous error -> 0; with a simultaneous accepted bad word -> 1.

## Timing
- Reset (async assert, any time, including mid-transfer): count=0, buffer contents discarded, `valid_o`=0, `data_o`=0, `perr_o`=0, `grant_o`=1 after reset state settles, `err_count_o`=0.
- Latency: word accepted at edge N is on `valid_o`/`data_o` from edge N (visible in cycle N+1) when buffer was empty; otherwise behind earlier entries.
- Throughput: 1 word/cycle when consumer grants every cycle.
- Simultaneous push and pop at count 1: count stays 1, head advances to new word.
- Full (count 2): `grant_o`=0 for that cycle even if `grant_i`=1; pop frees a slot, `grant_o`=1 next cycle.
- Empty with `grant_i`=1: no effect.
- Dropped word and pop in same cycle: count decrements by 1.

## Structure
- `parity_mode_t` {EVEN, ODD} and `parity_bit_choice_t` {LSB, MSB} live in `types_pkg`, shared with `top`.
- Sub-module `skid_buffer_2`: generic 2-entry valid/grant buffer parameterised on entry width; the stage wraps it with parity check, strip and counter logic.

## Test plan
All with DATA_WIDTH=8, ODD, MSB unless noted.
- Push `8'b1000_0000`, grant_i=1 -> next cycle `valid_o`=1, `data_o`=7'b000_0000, `perr_o`=0, `err_count_o`=0.
- Push `8'b0000_0011`, DROP_ON_ERROR=0 -> `data_o`=7'b000_0011, `perr_o`=1, `err_count_o`=1; same with DROP_ON_ERROR=1 -> `valid_o` stays 0, `err_count_o`=1.
- grant_i=0, push 3 good words -> `grant_o` drops after 2nd accepted; third held; raise grant_i -> 3 words out in order, none lost.
- ERR_CNT_WIDTH=2, 5 bad words -> counter 1,2,3,3,3; `err_clear_i` with a bad word same cycle -> 1.
- EVEN, LSB: push `8'b0000_0011` -> `data_o`=7'b000_0001, `perr_o`=0.
- Assert reset_n=0 with 2 words buffered -> `valid_o`=0, `err_count_o`=0 immediately; after release first push passes normally.
